// File: rtl/cpu_isa_pkg.sv
// ISA field positions, instruction type/op encodings and register-file size
// shared by the decode-side control blocks.
package cpu_isa_pkg;

  localparam int NUM_REGS = 8;
  localparam int REG_W    = $clog2(NUM_REGS);

  localparam int IMM_BIT = 31;
  localparam int TYPE_HI = 30;
  localparam int TYPE_LO = 29;
  localparam int OP_HI   = 28;
  localparam int OP_LO   = 26;
  localparam int RS1_HI  = 21;
  localparam int RS1_LO  = 19;
  localparam int RS2_HI  = 18;
  localparam int RS2_LO  = 16;

  typedef enum logic [1:0] {
    TYPE_NOP   = 2'b00,
    TYPE_ALU   = 2'b01,
    TYPE_MEM   = 2'b10,
    TYPE_AUDIO = 2'b11
  } instr_type_e;

  localparam logic [2:0] OP_MOVL = 3'b101;
  localparam logic [2:0] OP_MOVU = 3'b110;
  localparam logic [2:0] OP_MOVR = 3'b111;
  localparam logic [2:0] OP_LDL  = 3'b001;
  localparam logic [2:0] OP_LDU  = 3'b010;

endpackage

// File: rtl/operand_usage_decode.sv
// Combinational decode of which register fields the waiting instruction
// reads and whether it writes its destination.
module operand_usage_decode
  import cpu_isa_pkg::*;
(
  input  logic [31:0]      if_id_reg,
  output logic             uses_rs1,
  output logic             uses_rs2,
  output logic             writes_rd,
  output logic [REG_W-1:0] rs1,
  output logic [REG_W-1:0] rs2,
  output logic [REG_W-1:0] rd,
  output logic             is_nop
);

  instr_type_e itype;
  logic [2:0]  op;
  logic        imm;
  logic        unused_bits;

  assign itype       = instr_type_e'(if_id_reg[TYPE_HI:TYPE_LO]);
  assign op          = if_id_reg[OP_HI:OP_LO];
  assign imm         = if_id_reg[IMM_BIT];
  assign rs1         = if_id_reg[RS1_HI:RS1_LO];
  assign rs2         = if_id_reg[RS2_HI:RS2_LO];
  assign rd          = rs1;
  assign is_nop      = (itype == TYPE_NOP);
  assign unused_bits = ^{if_id_reg[25:22], if_id_reg[15:0]};

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    case (itype)
      TYPE_ALU: begin
        // every ALU-type op, move or arithmetic, writes rs1
        writes_rd = 1'b1;
        if (op == OP_MOVR) begin
          uses_rs2 = 1'b1;
        end else if (op != OP_MOVL && op != OP_MOVU) begin
          uses_rs1 = 1'b1;
          uses_rs2 = !imm;
        end
      end
      TYPE_MEM: begin
        uses_rs1  = 1'b1;
        uses_rs2  = !imm;
        writes_rd = (op == OP_LDL) || (op == OP_LDU);
      end
      TYPE_AUDIO: begin
        uses_rs1 = !imm;
        uses_rs2 = !imm;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register write-back countdown and decode-stage RAW stall generation,
// with a saturating count of hazard stall cycles.
module hazard_scoreboard
  import cpu_isa_pkg::*;
#(
  parameter int WB_LATENCY = 3,
  parameter int CNT_W      = $clog2(WB_LATENCY + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         if_id_reg,
  input  logic                ext_stall,
  output logic                decode_stall,
  output logic                hazard_stall,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [15:0]         stall_cycles
);

  logic             uses_rs1;
  logic             uses_rs2;
  logic             writes_rd;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic [REG_W-1:0] rd;
  logic             is_nop;
  logic             issue;
  logic [CNT_W-1:0] cnt [NUM_REGS];

  operand_usage_decode u_decode (
    .if_id_reg (if_id_reg),
    .uses_rs1  (uses_rs1),
    .uses_rs2  (uses_rs2),
    .writes_rd (writes_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .is_nop    (is_nop)
  );

  always_comb begin
    pending_mask = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      pending_mask[r] = (cnt[r] != '0);
    end
  end

  // Checked against the current counters, so a self-dependent instruction
  // stalls on the old write rather than its own.
  assign hazard_stall = (uses_rs1 && pending_mask[rs1]) ||
                        (uses_rs2 && pending_mask[rs2]);
  assign decode_stall = hazard_stall | ext_stall;
  assign issue        = !hazard_stall && !ext_stall && !is_nop;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else if (!ext_stall) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (issue && writes_rd && rd == REG_W'(r)) begin
          cnt[r] <= CNT_W'(WB_LATENCY);
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (hazard_stall && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized checks of hazard_scoreboard against a register
// pending-distance model built from the ISA operand rules.
module tb_hazard_scoreboard;

  localparam int WB = 3;

  logic        clock;
  logic        reset;
  logic [31:0] if_id_reg;
  logic        ext_stall;
  logic        decode_stall;
  logic        hazard_stall;
  logic [7:0]  pending_mask;
  logic [15:0] stall_cycles;

  int compared   = 0;
  int mismatched = 0;
  int mcnt [8];
  int msc;

  hazard_scoreboard #(.WB_LATENCY(WB)) dut (
    .clock        (clock),
    .reset        (reset),
    .if_id_reg    (if_id_reg),
    .ext_stall    (ext_stall),
    .decode_stall (decode_stall),
    .hazard_stall (hazard_stall),
    .pending_mask (pending_mask),
    .stall_cycles (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input bit imm, input bit [1:0] t,
                                     input bit [2:0] op, input bit [2:0] a,
                                     input bit [2:0] b);
    return {imm, t, op, 4'b0000, a, b, 16'h0000};
  endfunction

  // Registers read by an instruction, as a bitmask.
  function automatic logic [7:0] src_mask(input logic [31:0] ins);
    logic [7:0] m;
    int t, op, a, b;
    logic imm;
    m   = '0;
    t   = int'(ins[30:29]);
    op  = int'(ins[28:26]);
    imm = ins[31];
    a   = int'(ins[21:19]);
    b   = int'(ins[18:16]);
    if (t == 1) begin
      if (op == 7) m[b] = 1'b1;
      else if (op < 5) begin
        m[a] = 1'b1;
        if (!imm) m[b] = 1'b1;
      end
    end else if (t == 2) begin
      m[a] = 1'b1;
      if (!imm) m[b] = 1'b1;
    end else if (t == 3 && !imm) begin
      m[a] = 1'b1;
      m[b] = 1'b1;
    end
    return m;
  endfunction

  // Destination register, or -1 when the instruction writes nothing.
  function automatic int dst_reg(input logic [31:0] ins);
    int t, op;
    t  = int'(ins[30:29]);
    op = int'(ins[28:26]);
    if (t == 1 || (t == 2 && (op == 1 || op == 2))) return int'(ins[21:19]);
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    if_id_reg = '0;
    ext_stall = 1'b0;
    @(posedge clock);
    for (int r = 0; r < 8; r++) mcnt[r] = 0;
    msc = 0;
  endtask

  // One decode cycle: drive, check all outputs against the model, advance it.
  task automatic step(input logic [31:0] ins, input logic ext, output logic adv);
    logic [7:0] pend;
    logic hz;
    int d;
    @(negedge clock);
    reset     = 1'b0;
    if_id_reg = ins;
    ext_stall = ext;
    #1;
    pend = '0;
    for (int r = 0; r < 8; r++) pend[r] = (mcnt[r] != 0);
    hz = |(src_mask(ins) & pend);
    chk("hazard_stall", 32'(hazard_stall), 32'(hz));
    chk("decode_stall", 32'(decode_stall), 32'(hz | ext));
    chk("pending_mask", 32'(pending_mask), 32'(pend));
    chk("stall_cycles", 32'(stall_cycles), 32'(msc));
    adv = !hz && !ext;
    if (hz && msc < 32'hFFFF) msc++;
    if (!ext) begin
      for (int r = 0; r < 8; r++) if (mcnt[r] > 0) mcnt[r]--;
      d = dst_reg(ins);
      if (adv && ins[30:29] != 2'b00 && d >= 0) mcnt[d] = WB;
    end
  endtask

  task automatic run_until_issue(input logic [31:0] ins, input logic [7:0] ext_pat,
                                 input int preg, output int n_hz, output int n_ds,
                                 output int n_pm);
    logic adv;
    n_hz = 0;
    n_ds = 0;
    n_pm = 0;
    adv  = 1'b0;
    for (int k = 0; k < 60 && !adv; k++) begin
      step(ins, (k < 8) ? ext_pat[k] : 1'b0, adv);
      if (hazard_stall) n_hz++;
      if (decode_stall) n_ds++;
      if (pending_mask[preg] && !adv) n_pm++;
    end
    chk("issue_within_bound", 32'(adv), 32'd1);
  endtask

  initial begin
    logic adv;
    int nh, nd, np;
    logic [31:0] cur;
    logic ext;

    reset     = 1'b1;
    if_id_reg = '0;
    ext_stall = 1'b0;

    // Reset then nop stream
    do_reset();
    for (int i = 0; i < 5; i++) step(32'h0, 1'b0, adv);
    chk("nop_hazard", 32'(hazard_stall), 32'd0);
    chk("nop_pending", 32'(pending_mask), 32'd0);
    chk("nop_stall_cycles", 32'(stall_cycles), 32'd0);

    // Back-to-back RAW on r2
    step(mk(1, 2'b01, 3'b000, 3'd2, 3'd0), 1'b0, adv);
    run_until_issue(mk(0, 2'b01, 3'b000, 3'd2, 3'd0), 8'h00, 2, nh, nd, np);
    chk("raw_stall_len", 32'(nh), 32'd3);
    chk("raw_pending_len", 32'(np), 32'd3);
    step(32'h0, 1'b0, adv);
    chk("raw_stall_cycles", 32'(stall_cycles), 32'd3);

    // Two independent instructions between writer and reader
    do_reset();
    step(mk(1, 2'b01, 3'b000, 3'd4, 3'd0), 1'b0, adv);
    step(mk(1, 2'b01, 3'b000, 3'd6, 3'd6), 1'b0, adv);
    step(mk(1, 2'b01, 3'b011, 3'd7, 3'd7), 1'b0, adv);
    run_until_issue(mk(0, 2'b01, 3'b000, 3'd4, 3'd0), 8'h00, 4, nh, nd, np);
    chk("gap2_stall_len", 32'(nh), 32'd1);

    // External freeze mid-countdown
    do_reset();
    step(mk(1, 2'b01, 3'b000, 3'd5, 3'd0), 1'b0, adv);
    run_until_issue(mk(0, 2'b01, 3'b000, 3'd5, 3'd0), 8'b0000_0110, 5, nh, nd, np);
    chk("freeze_hazard_len", 32'(nh), 32'd5);
    chk("freeze_decode_hold", 32'(nd), 32'd5);

    // Move-lower into a pending register: no stall, reloads counter
    do_reset();
    step(mk(1, 2'b01, 3'b000, 3'd3, 3'd0), 1'b0, adv);
    step(mk(1, 2'b01, 3'b101, 3'd3, 3'd0), 1'b0, adv);
    chk("movl_no_stall", 32'(hazard_stall), 32'd0);
    run_until_issue(mk(0, 2'b01, 3'b000, 3'd3, 3'd0), 8'h00, 3, nh, nd, np);
    chk("movl_reload_stall", 32'(nh), 32'd3);

    // Audio immediate vs register form on pending rs2
    do_reset();
    step(mk(1, 2'b01, 3'b000, 3'd6, 3'd0), 1'b0, adv);
    step(mk(1, 2'b11, 3'b000, 3'd0, 3'd6), 1'b0, adv);
    chk("audio_imm_no_stall", 32'(hazard_stall), 32'd0);
    run_until_issue(mk(0, 2'b11, 3'b000, 3'd0, 3'd6), 8'h00, 6, nh, nd, np);
    chk("audio_reg_stall", 32'(nh), 32'd2);

    // Drive stall_cycles into saturation with a frozen hazard
    do_reset();
    step(mk(1, 2'b01, 3'b000, 3'd1, 3'd0), 1'b0, adv);
    for (int i = 0; i < 65540; i++) step(mk(0, 2'b01, 3'b000, 3'd1, 3'd0), 1'b1, adv);
    chk("sat_reached", 32'(stall_cycles), 32'hFFFF);
    run_until_issue(mk(0, 2'b01, 3'b000, 3'd1, 3'd0), 8'h00, 1, nh, nd, np);
    chk("sat_tail_stall", 32'(nh), 32'd3);
    step(32'h0, 1'b0, adv);
    chk("sat_holds", 32'(stall_cycles), 32'hFFFF);

    // Randomized stream: instruction held in IF/ID until it advances
    do_reset();
    cur = $urandom();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        cur = $urandom();
      end
      ext = ($urandom_range(0, 4) == 0);
      step(cur, ext, adv);
      if (adv) cur = $urandom();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Register-hazard controller for the in-order pipeline. It inspects the instruction waiting in the IF/ID register and tracks, per architectural register, how many cycles remain until an in-flight write reaches the register file. It raises the decode-stage stall whenever the waiting instruction reads a register with a pending write. Sits beside the decode stage; its stall output drives decode's `stall` input and the fetch hold.

## Interface
Parameters:
- `WB_LATENCY`, default 3: cycles from a writer leaving decode until a reader in decode sees the written value.
- `CNT_W`, default `$clog2(WB_LATENCY+1)`: width of each pending counter.

Ports:
- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `if_id_reg` in 32: instruction presented to decode this cycle.
- `ext_stall` in 1: freeze request from downstream (memory/audio); the pipeline holds.
- `decode_stall` out 1: `hazard_stall | ext_stall`; drives decode `stall` and fetch hold.
- `hazard_stall` out 1: the waiting instruction has an unresolved source dependency.
- `pending_mask` out 8: bit r set when register r's counter is nonzero.
- `stall_cycles` out 16: saturating count of cycles with `hazard_stall=1`.

## Operation
- Field decode, with bit positions per the ISA:
  - `imm=[31]`, `type=[30:29]`, `op=[28:26]`, `rs1=[21:19]`, `rs2=[18:16]`.
  - Types: 00 nop, 01 ALU/move, 10 memory, 11 audio.
  - Move is `type 01` with op ∈ {101 move-lower, 110 move-upper, 111 move-reg}. All other `type 01` ops are arithmetic.
- Source use:
  - Arithmetic: rs1; rs2 only if `imm=0`.
  - Move-lower/upper: none.
  - Move-reg: rs2.
  - Memory: rs1; rs2 only if `imm=0`.
  - Audio: rs1 and rs2 if `imm=0`; none if `imm=1`.
  - Nop: none.
- Destination write: rs1 field. An instruction writes when it is any move, any arithmetic, or memory op 001 or 010. Half-word writes count as a full-register hazard.
- `hazard_stall` is combinational: (uses rs1 and cnt[rs1]≠0) or (uses rs2 and cnt[rs2]≠0).
- Issue: `issue = !hazard_stall && !ext_stall && type≠00`.
- Counter update each posedge, in priority order:
  1. `reset`: all counters cleared to 0.
  2. `ext_stall=1`: all counters hold.
  3. Otherwise, every nonzero counter decrements by 1.
  4. If `issue` and the instruction writes, cnt[rs1] loads `WB_LATENCY`. The load overrides the decrement of the same register.
- A stalled instruction never loads its counter. It loads on the cycle it finally issues.
- Self-dependency (e.g. rs1 read and written): stall is evaluated against the old counter; the load happens only on issue.
- `stall_cycles`:
  - Increments when `hazard_stall=1`, including cycles where `ext_stall` is also high.
  - Saturates at 16'hFFFF.
  - Cleared by `reset`.

## Timing
- Reset values:
  - Counters 0, so `pending_mask=0` and `hazard_stall=0`.
  - `decode_stall=ext_stall`.
  - `stall_cycles=0`.
- Stall latency: zero cycles. `hazard_stall` is valid in the same cycle `if_id_reg` changes.
- Back-to-back RAW, writer issued at edge T (counter = `WB_LATENCY` after T):
  - Reader stalls at cycles T..T+`WB_LATENCY`-1.
  - Reader issues at edge T+`WB_LATENCY`.
  - Stall length is `WB_LATENCY` cycles for an immediately dependent instruction. It shortens by one for each independent instruction in between.
- `ext_stall` mid-countdown: counters freeze. The remaining distance is preserved exactly.
- Reset mid-operation: all pending hazards drop the next cycle. Upstream flush on reset is the top level's responsibility.
- Two writers to the same register issued consecutively: the second reloads to `WB_LATENCY`.

## Structure
- Shared package `cpu_isa_pkg` holds:
  - Type constants (`TYPE_NOP`, `TYPE_ALU`, `TYPE_MEM`, `TYPE_AUDIO`).
  - Move op codes (`OP_MOVL`, `OP_MOVU`, `OP_MOVR`) and load ops (`OP_LDL`, `OP_LDU`).
  - Field bit positions and `NUM_REGS=8`.
- One sub-module, `operand_usage_decode`, is combinational. It maps `if_id_reg` to `uses_rs1`, `uses_rs2`, `writes_rd`, `rs1`, `rs2`, `rd`, `is_nop`.
- Top level holds the 8 counters, the stall logic and the perf counter.

## Test plan
- Reset, then a nop stream: `hazard_stall=0`, `pending_mask=0`, `stall_cycles=0` throughout.
- Arithmetic writing r2, followed immediately by arithmetic with rs1=r2 (`imm=0`): exactly 3 stall cycles; `pending_mask[2]` high for 3 cycles; `stall_cycles=3`.
- Writer to r4, then two independent instructions, then a reader of r4: 1 stall cycle.
- Writer to r5, then a reader of r5 with `ext_stall` pulsed for 2 cycles during the countdown: total decode hold is 5 cycles, and `hazard_stall` is high for 3 non-frozen plus 2 frozen cycles (5 in total).
- Move-lower immediate into r3 while r3 is pending: no stall (no source use). Issue reloads cnt[3]=3.
- Audio immediate with rs2 pending: no stall. The same instruction with `imm=0`: stall until cnt[rs2]=0. Additionally, force `stall_cycles` to 16'hFFFF and stall once more: it stays at 16'hFFFF.
